otter_dmem_responder: RTL and testbench
=======================================

Name: otter_dmem_responder

Overview:
Data-memory responder for the OTTER core. It services the load/store requests that the control decoder raises on MEM_RDEN2/MEM_WE2 during the memory stage. The block latches each request and holds it for a configurable latency, during which it stalls the pipeline. It then performs the byte/half/word access against an internal word-organised RAM and returns sign- or zero-extended load data with a one-cycle valid pulse.

Parameters:
ADDR_WIDTH, 14, word-index bits; RAM depth = 2**ADDR_WIDTH words of 32 bits
LATENCY, 2, cycles from request acceptance edge to response edge; legal range 1..15

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-high reset
MEM_RDEN2  input  1  load request
MEM_WE2  input  1  store request
MEM_ADDR2  input  32  byte address (ALU result)
MEM_DIN2  input  32  store data (rs2)
MEM_SIZE  input  2  funct3[1:0]: 00 byte, 01 half, 10 word, 11 treated as word
MEM_UNSIGNED  input  1  funct3[2]: 1 = zero-extend load
MEM_DOUT2  output  32  extended load data, valid while MEM_VALID=1
MEM_VALID  output  1  one-cycle response pulse (loads and stores)
MEM_BUSY  output  1  stall request to the pipeline
MEM_ERR  output  1  misaligned-access flag, qualified by MEM_VALID

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (CLK, RST).
- Reset values: state IDLE, MEM_VALID=0, MEM_BUSY=0, MEM_ERR=0, MEM_DOUT2=0, latency counter 0. RAM contents are not reset.
- FSM states: IDLE and WAIT.
- Acceptance:
  - In IDLE, a request is accepted on the rising edge E0 when MEM_RDEN2|MEM_WE2 is high.
  - On E0 the block latches ADDR, DIN, SIZE, UNSIGNED and the operation type.
  - If both MEM_RDEN2 and MEM_WE2 are high, the access is a store and no load data is returned.
- Latency:
  - The response edge is ER = E0 + (LATENCY-1) cycles.
  - LATENCY=1: ER = E0, so the FSM stays in IDLE and MEM_BUSY is never asserted.
  - LATENCY>1: IDLE->WAIT at E0, counter loads LATENCY-1. WAIT decrements each edge and returns to IDLE at ER, when the counter reaches 1.
  - MEM_BUSY = (state==WAIT), combinational.
- Response:
  - MEM_VALID is high for exactly the one cycle following ER.
  - Store bytes commit to RAM at ER.
  - Load data is read from RAM at ER and registered into MEM_DOUT2.
  - MEM_DOUT2 holds its value until the next load response. It is 0 after a store response.
- Back-to-back: the FSM is in IDLE during the MEM_VALID cycle, so a new request can be accepted on the next edge. Peak throughput is one access per LATENCY cycles.
- Requests asserted while in WAIT are ignored. The requester must hold them until MEM_BUSY falls.
- Addressing:
  - Word index = MEM_ADDR2[ADDR_WIDTH+1:2].
  - Upper address bits are ignored, so accesses wrap modulo RAM size.
  - Lane select = ADDR[1:0].
- Stores:
  - Byte: DIN[7:0] is written to lane ADDR[1:0]; other lanes are unchanged.
  - Half: DIN[15:0] is written to lanes {ADDR[1],0}+1 : {ADDR[1],0}.
  - Word: the full word is written.
- Loads:
  - The selected byte or half is right-justified in MEM_DOUT2.
  - It is sign-extended when MEM_UNSIGNED=0 and zero-extended when MEM_UNSIGNED=1.
  - Word loads ignore MEM_UNSIGNED.
- Misalignment: a half access with ADDR[0]=1, or a word access with ADDR[1:0]!=0. Handling depends on the optional feature below.
- Reset mid-operation: the FSM returns to IDLE immediately, the pending store is discarded (RAM unchanged) and no MEM_VALID is produced.

Optional Feature:
DMEM_MISALIGN_TRAP_EN
- Defined:
  - A misaligned access performs no RAM write.
  - MEM_DOUT2 = 0.
  - MEM_ERR=1 during its MEM_VALID cycle.
  - Latency and handshake are unchanged.
- Undefined:
  - MEM_ERR is tied 0.
  - Misaligned accesses proceed with the offending low address bits forced to 0: a half access aligns to ADDR[1], a word access aligns to lane 0.

Test Plan:
- LATENCY=2. Store word 0xDEADBEEF @0x100, then load word @0x100 -> MEM_BUSY high 1 cycle per access; MEM_VALID pulses 1 cycle after E0+1; load returns DOUT=0xDEADBEEF.
- Store byte 0x80 @0x103 over 0x11223344, then LB and LBU @0x103 -> word becomes 0x80223344; LB returns 0xFFFFFF80; LBU returns 0x00000080.
- Store half 0xBEEF @0x202, then LH @0x202 and LW @0x200 -> LH returns 0xFFFFBEEF; word = 0xBEEFxxxx with lower half unchanged.
- Hold MEM_RDEN2 during WAIT, then issue a back-to-back load in the MEM_VALID cycle -> WAIT-cycle request ignored; second request accepted on the next edge; exactly two VALID pulses.
- Assert RST in WAIT of a store 0x12345678 @0x300, then load @0x300 -> no VALID for the store; RAM retains its prior value.
- With DMEM_MISALIGN_TRAP_EN: SW @0x301 -> MEM_ERR=1 with VALID, RAM unchanged. Without it: the store lands at 0x300 and MEM_ERR=0.

Source files
------------

// File: rtl/otter_dmem_responder.sv
// OTTER data-memory responder: word RAM with byte/half/word access and a LATENCY-cycle stall per request.
// Response: MEM_VALID pulses the cycle after edge E0+LATENCY-1; requests seen in WAIT are ignored (requester holds).
// Optional: define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses on MEM_ERR instead of silently aligning them.
module otter_dmem_responder #(
    parameter int ADDR_WIDTH = 14,
    parameter int LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_RDEN2,
    input  logic        MEM_WE2,
    input  logic [31:0] MEM_ADDR2,
    input  logic [31:0] MEM_DIN2,
    input  logic [1:0]  MEM_SIZE,
    input  logic        MEM_UNSIGNED,
    output logic [31:0] MEM_DOUT2,
    output logic        MEM_VALID,
    output logic        MEM_BUSY,
    output logic        MEM_ERR
);
    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0]           r_din;
    logic [1:0]            r_size;
    logic                  r_uns;
    logic                  r_store;
    logic [31:0]           r_dout;
    logic                  r_valid;
    logic                  r_err;

    logic                  w_req;
    logic                  w_idle;
    logic                  w_fire;
    logic [ADDR_WIDTH+1:0] w_addr;
    logic [31:0]           w_din;
    logic [1:0]            w_size;
    logic                  w_uns;
    logic                  w_store;
    logic                  w_mis;
    logic                  w_trap;
    logic [1:0]            w_lane;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_rword;
    logic [31:0]           w_sh;
    logic [31:0]           w_ldata;
    logic                  w_we;
    logic                  w_unused_addr;

    assign w_unused_addr = ^MEM_ADDR2[31:ADDR_WIDTH+2];

    assign w_req  = MEM_RDEN2 | MEM_WE2;
    assign w_idle = (r_state == ST_IDLE);
    // With LATENCY=1 the acceptance edge is also the response edge, so the live inputs drive the access.
    assign w_fire = (w_idle && w_req && (LATENCY == 1)) || (!w_idle && (r_cnt == 4'd1));

    assign w_addr  = w_idle ? MEM_ADDR2[ADDR_WIDTH+1:0] : r_addr;
    assign w_din   = w_idle ? MEM_DIN2     : r_din;
    assign w_size  = w_idle ? MEM_SIZE     : r_size;
    assign w_uns   = w_idle ? MEM_UNSIGNED : r_uns;
    assign w_store = w_idle ? MEM_WE2      : r_store;

    assign w_mis  = ((w_size == 2'b01) && w_addr[0]) || (w_size[1] && (w_addr[1:0] != 2'b00));
    assign w_trap = TRAP_EN && w_mis;
    assign w_idx  = w_addr[ADDR_WIDTH+1:2];

    always_comb begin
        w_lane  = w_addr[1:0];
        w_be    = 4'b0001 << w_addr[1:0];
        w_wdata = {4{w_din[7:0]}};
        case (w_size)
            2'b00: ;
            2'b01: begin
                w_lane  = {w_addr[1], 1'b0};
                w_be    = 4'b0011 << {w_addr[1], 1'b0};
                w_wdata = {2{w_din[15:0]}};
            end
            default: begin
                w_lane  = 2'b00;
                w_be    = 4'b1111;
                w_wdata = w_din;
            end
        endcase
    end

    assign w_rword = r_mem[w_idx];
    assign w_sh    = w_rword >> {w_lane, 3'b000};

    always_comb begin
        w_ldata = w_sh;
        case (w_size)
            2'b00:   w_ldata = w_uns ? {24'd0, w_sh[7:0]}  : {{24{w_sh[7]}}, w_sh[7:0]};
            2'b01:   w_ldata = w_uns ? {16'd0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
            default: w_ldata = w_sh;
        endcase
    end

    assign w_we = w_fire && w_store && !w_trap && !RST;

    always_ff @(posedge CLK) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_din   <= 32'd0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_store <= 1'b0;
            r_dout  <= 32'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_fire) begin
                r_valid <= 1'b1;
                r_err   <= w_trap;
                r_dout  <= (w_store || w_trap) ? 32'd0 : w_ldata;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr  <= MEM_ADDR2[ADDR_WIDTH+1:0];
                        r_din   <= MEM_DIN2;
                        r_size  <= MEM_SIZE;
                        r_uns   <= MEM_UNSIGNED;
                        r_store <= MEM_WE2;
                        if (LATENCY > 1) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= LAT_M1;
                        end
                    end
                end
                default: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign MEM_DOUT2 = r_dout;
    assign MEM_VALID = r_valid;
    assign MEM_ERR   = r_err;
    assign MEM_BUSY  = (r_state == ST_WAIT);
endmodule

// File: tb/tb_otter_dmem_responder.sv
// Randomized bench for otter_dmem_responder against a byte-addressed reference memory model.
module tb_otter_dmem_responder;
    localparam int AW      = 14;
    localparam int LATENCY = 2;
    localparam logic [31:0] BMASK = (32'h1 << (AW + 2)) - 32'h1;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        MEM_RDEN2, MEM_WE2, MEM_UNSIGNED;
    logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
    logic [1:0]  MEM_SIZE;
    logic        MEM_VALID, MEM_BUSY, MEM_ERR;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] mdl [int];

    otter_dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LATENCY)) dut (
        .CLK(CLK), .RST(RST), .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2),
        .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE),
        .MEM_UNSIGNED(MEM_UNSIGNED), .MEM_DOUT2(MEM_DOUT2), .MEM_VALID(MEM_VALID),
        .MEM_BUSY(MEM_BUSY), .MEM_ERR(MEM_ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit misal(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] eff_addr(input logic [31:0] a, input logic [1:0] sz);
        int n = nbytes(sz);
        return (a - (a % n)) & BMASK;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        logic [31:0] ea = eff_addr(a, sz);
        for (int i = 0; i < nbytes(sz); i++) mdl[int'((ea + i) & BMASK)] = d[8*i +: 8];
    endtask

    task automatic model_load(input logic [31:0] a, input logic [1:0] sz, input bit u,
                              output logic [31:0] v, output bit known);
        logic [31:0] ea = eff_addr(a, sz);
        int n = nbytes(sz);
        v = 32'd0;
        known = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (mdl.exists(int'((ea + i) & BMASK))) v[8*i +: 8] = mdl[int'((ea + i) & BMASK)];
            else known = 1'b0;
        end
        if (n == 1 && !u && v[7])  v = v | 32'hFFFF_FF00;
        if (n == 2 && !u && v[15]) v = v | 32'hFFFF_0000;
    endtask

    task automatic access(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input bit u, input bit hold, input string tag,
                          output logic [31:0] got);
        logic [31:0] exp;
        bit known, trap, seen;
        int n;
        trap  = TRAP && misal(a, sz);
        known = 1'b1;
        exp   = 32'd0;
        if (we) begin
            if (!trap) model_store(a, d, sz);
        end else if (!trap) begin
            model_load(a, sz, u, exp, known);
        end
        MEM_WE2 = we; MEM_RDEN2 = re; MEM_ADDR2 = a; MEM_DIN2 = d;
        MEM_SIZE = sz; MEM_UNSIGNED = u;
        @(posedge CLK);
        seen = 1'b0;
        n    = 0;
        got  = 32'd0;
        while (!seen && n < LATENCY + 3) begin
            @(negedge CLK);
            n++;
            if (!hold || !MEM_BUSY) begin
                MEM_WE2 = 1'b0; MEM_RDEN2 = 1'b0;
            end
            if (MEM_VALID) begin
                seen = 1'b1;
                got  = MEM_DOUT2;
                check_eq({tag, "_lat"}, n, LATENCY);
                if (known) check_eq({tag, "_dout"}, MEM_DOUT2, exp);
                check_eq({tag, "_err"}, {31'd0, MEM_ERR}, {31'd0, trap});
                check_eq({tag, "_busy_rsp"}, {31'd0, MEM_BUSY}, 32'd0);
            end else begin
                check_eq({tag, "_busy"}, {31'd0, MEM_BUSY}, 32'd1);
            end
        end
        if (!seen) check_eq({tag, "_valid_timeout"}, {31'd0, MEM_VALID}, 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        bit any_valid;
        RST = 1'b1;
        MEM_RDEN2 = 1'b0; MEM_WE2 = 1'b0; MEM_ADDR2 = 32'd0; MEM_DIN2 = 32'd0;
        MEM_SIZE = 2'b00; MEM_UNSIGNED = 1'b0;
        repeat (2) @(negedge CLK);
        check_eq("rst_valid", {31'd0, MEM_VALID}, 32'd0);
        check_eq("rst_busy",  {31'd0, MEM_BUSY},  32'd0);
        check_eq("rst_err",   {31'd0, MEM_ERR},   32'd0);
        check_eq("rst_dout",  MEM_DOUT2, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        access(1, 0, 32'h100, 32'hDEADBEEF, 2'b10, 0, 0, "sw100", got);
        access(0, 1, 32'h100, 32'd0, 2'b10, 0, 0, "lw100", got);
        check_eq("lw100_lit", got, 32'hDEADBEEF);

        access(1, 0, 32'h100, 32'h11223344, 2'b10, 0, 0, "sw100b", got);
        access(1, 0, 32'h103, 32'hFFFFFF80, 2'b00, 0, 0, "sb103", got);
        access(0, 1, 32'h100, 32'd0, 2'b10, 0, 0, "lw100b", got);
        check_eq("lw100b_lit", got, 32'h80223344);
        @(negedge CLK);
        check_eq("dout_hold", MEM_DOUT2, 32'h80223344);
        access(0, 1, 32'h103, 32'd0, 2'b00, 0, 0, "lb103", got);
        check_eq("lb103_lit", got, 32'hFFFFFF80);
        access(0, 1, 32'h103, 32'd0, 2'b00, 1, 0, "lbu103", got);
        check_eq("lbu103_lit", got, 32'h00000080);
        access(0, 1, 32'h0001_0100, 32'd0, 2'b10, 0, 0, "lw_wrap", got);
        check_eq("lw_wrap_lit", got, 32'h80223344);

        access(1, 0, 32'h200, 32'h55667788, 2'b10, 0, 0, "sw200", got);
        access(1, 0, 32'h202, 32'h0000BEEF, 2'b01, 0, 0, "sh202", got);
        access(0, 1, 32'h202, 32'd0, 2'b01, 0, 0, "lh202", got);
        check_eq("lh202_lit", got, 32'hFFFFBEEF);
        access(0, 1, 32'h200, 32'd0, 2'b10, 0, 0, "lw200", got);
        check_eq("lw200_lit", got, 32'hBEEF7788);

        access(1, 1, 32'h204, 32'hA5A5_0F0F, 2'b10, 0, 0, "both204", got);
        check_eq("both204_lit", got, 32'd0);
        access(0, 1, 32'h204, 32'd0, 2'b10, 0, 1, "hold204", got);
        access(0, 1, 32'h200, 32'd0, 2'b10, 0, 0, "b2b200", got);
        check_eq("b2b200_lit", got, 32'hBEEF7788);

        access(1, 0, 32'h300, 32'hAAAA5555, 2'b10, 0, 0, "sw300", got);
        MEM_WE2 = 1'b1; MEM_RDEN2 = 1'b0; MEM_ADDR2 = 32'h300; MEM_DIN2 = 32'h12345678;
        MEM_SIZE = 2'b10; MEM_UNSIGNED = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_eq("rstmid_busy", {31'd0, MEM_BUSY}, 32'd1);
        MEM_WE2 = 1'b0;
        RST = 1'b1;
        #1;
        check_eq("rstmid_busy_drop", {31'd0, MEM_BUSY}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        any_valid = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            if (MEM_VALID) any_valid = 1'b1;
        end
        check_eq("rstmid_novalid", {31'd0, any_valid}, 32'd0);
        access(0, 1, 32'h300, 32'd0, 2'b10, 0, 0, "lw300", got);
        check_eq("lw300_lit", got, 32'hAAAA5555);

        access(1, 0, 32'h301, 32'hCAFEF00D, 2'b10, 0, 0, "sw301", got);
        access(0, 1, 32'h300, 32'd0, 2'b10, 0, 0, "lw300b", got);
        check_eq("lw300b_lit", got, TRAP ? 32'hAAAA5555 : 32'hCAFEF00D);
        access(0, 1, 32'h203, 32'd0, 2'b01, 1, 0, "lh203", got);
        check_eq("lh203_lit", got, TRAP ? 32'd0 : 32'h0000BEEF);

        for (int w = 0; w < 16; w++)
            access(1, 0, w * 4, $urandom, 2'b10, 0, 0, "init", got);
        for (int k = 0; k < 200; k++) begin
            bit we, re;
            logic [31:0] a;
            we = 1'($urandom % 2);
            re = we ? 1'($urandom % 2) : 1'b1;
            a  = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 63);
            access(we, re, a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom % 2),
                   1'($urandom % 2), "rnd", got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
